// File: rtl/dc_rx_sched_if.sv
// ---------------------------------------------------------------------------
// dc_rx_sched_if
// Bus between the frame scheduler, the lane source and the DC receive chain.
//
//   tx_sig / tx_sig_tvalid    : 8 lanes x 32-bit two's complement samples from
//                               the source, with one valid bit per lane.
//   chain_sig / chain_sig_tvalid : gated copy of the source beat into the chain.
//   rx_sig_tvalid             : per-lane valid at the output of the chain.
//   chain_rst                 : active-high flush reset into the chain.
//
// Handshake: there is no ready. A beat is transferred in every cycle in which
// its tvalid is 8'hFF, and the receiver must take it in that cycle. A tvalid of
// zero means no beat. Any other pattern is a malformed beat; the scheduler
// treats it as a lane fault on the input side and ignores it on the output side.
//
// Modports:
//   master : the side that sources tx_sig and observes the chain (bench/system).
//   slave  : the scheduler.
// ---------------------------------------------------------------------------
interface dc_rx_sched_if;
    logic [7:0][31:0] tx_sig;
    logic [7:0]       tx_sig_tvalid;
    logic [7:0][31:0] chain_sig;
    logic [7:0]       chain_sig_tvalid;
    logic [7:0]       rx_sig_tvalid;
    logic             chain_rst;

    modport master (
        output tx_sig, tx_sig_tvalid, rx_sig_tvalid,
        input  chain_sig, chain_sig_tvalid, chain_rst
    );

    modport slave (
        input  tx_sig, tx_sig_tvalid, rx_sig_tvalid,
        output chain_sig, chain_sig_tvalid, chain_rst
    );
endinterface

// File: rtl/dc_rx_sched.sv
// ---------------------------------------------------------------------------
// dc_rx_sched
// Frame scheduler and watchdog in front of the DC receive chain.
// Admits 8-lane beats into the chain only on whole-frame boundaries, for a
// programmed number of frames (or continuously when the count is 0), counts
// the frames leaving the chain, drains before reporting done, and pulses a
// flush reset into the chain on a lane fault or an output stall.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset.
//   cfg_enable      : run permission; dropping it ends the burst at the next
//                     frame boundary.
//   cfg_start       : one-cycle start request (ignored unless cfg_enable).
//   cfg_num_frames  : frames per burst, 0 = continuous.
//   bus             : slave side of dc_rx_sched_if (data, valids, chain_rst).
//   busy            : state != IDLE.
//   done            : one-cycle pulse in the cycle DRAIN returns to IDLE.
//   err_lane        : sticky, partial input valid seen in RUN.
//   err_timeout     : sticky, watchdog expired.
//   frames_in_cnt   : frames admitted in this burst.
//   frames_out_cnt  : frames received from the chain in this burst.
//   state           : IDLE=0, RUN=1, DRAIN=2, FLUSH=3.
// ---------------------------------------------------------------------------
module dc_rx_sched #(
    parameter int IN_BEATS     = 8,
    parameter int OUT_BEATS    = 8,
    parameter int TIMEOUT      = 1024,
    parameter int FLUSH_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_frames,
    dc_rx_sched_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             err_lane,
    output logic             err_timeout,
    output logic [CNT_W-1:0] frames_in_cnt,
    output logic [CNT_W-1:0] frames_out_cnt,
    output logic [2:0]       state
);

    localparam int IB_W = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OB_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [IB_W-1:0] IB_LAST = IB_W'(IN_BEATS - 1);
    localparam logic [OB_W-1:0] OB_LAST = OB_W'(OUT_BEATS - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_FLUSH = 3'd3
    } state_t;

    state_t state_q, state_d;

    logic [IB_W-1:0]  in_beat_cnt, in_beat_nxt;
    logic [OB_W-1:0]  out_beat_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] num_frames_q;
    logic [CNT_W-1:0] frames_in_nxt;

    logic in_full, in_partial, out_full;
    logic counting, outstanding, out_take, wd_expire;
    logic start_ok, admit, in_wrap, lane_fault;

    assign in_full    = (bus.tx_sig_tvalid == 8'hFF);
    assign in_partial = (bus.tx_sig_tvalid != 8'h00) && !in_full;
    assign out_full   = (bus.rx_sig_tvalid == 8'hFF);

    // Counters wrap modulo 2^CNT_W in continuous mode, so "something is
    // outstanding" is simply inequality of the two frame counters.
    assign counting    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign outstanding = (frames_in_cnt != frames_out_cnt);
    // Output beats with nothing outstanding are surplus and ignored, which is
    // what keeps frames_out_cnt from overtaking frames_in_cnt.
    assign out_take    = counting && out_full && outstanding;
    // An output beat in the expiry cycle wins over the watchdog.
    assign wd_expire   = counting && outstanding && !out_take && (wd_cnt == WD_LAST);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and admission control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        start_ok      = 1'b0;
        admit         = 1'b0;
        in_wrap       = 1'b0;
        lane_fault    = 1'b0;
        in_beat_nxt   = in_beat_cnt;
        frames_in_nxt = frames_in_cnt;
        case (state_q)
            S_IDLE: begin
                if (cfg_start && cfg_enable) begin
                    start_ok = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // A lane fault takes priority over a boundary exit.
                if (in_partial) begin
                    lane_fault = 1'b1;
                    state_d    = S_FLUSH;
                end else if (wd_expire) begin
                    state_d = S_FLUSH;
                end else begin
                    admit   = in_full;
                    in_wrap = admit && (in_beat_cnt == IB_LAST);
                    if (admit) begin
                        in_beat_nxt = in_wrap ? '0 : in_beat_cnt + IB_W'(1);
                    end
                    if (in_wrap) begin
                        frames_in_nxt = frames_in_cnt + CNT_W'(1);
                    end
                    // Exit only on a frame boundary, so a frame that has
                    // started is always admitted in full.
                    if ((in_beat_nxt == '0) &&
                        (((num_frames_q != '0) && (frames_in_nxt == num_frames_q)) ||
                         !cfg_enable)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!outstanding) begin
                    state_d = S_IDLE;
                end else if (wd_expire) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == FL_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame counters, watchdog and sticky errors
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_beat_cnt    <= '0;
            out_beat_cnt   <= '0;
            frames_in_cnt  <= '0;
            frames_out_cnt <= '0;
            num_frames_q   <= '0;
            wd_cnt         <= '0;
            err_lane       <= 1'b0;
            err_timeout    <= 1'b0;
        end else if (start_ok) begin
            in_beat_cnt    <= '0;
            out_beat_cnt   <= '0;
            frames_in_cnt  <= '0;
            frames_out_cnt <= '0;
            num_frames_q   <= cfg_num_frames;
            wd_cnt         <= '0;
            err_lane       <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            in_beat_cnt   <= in_beat_nxt;
            frames_in_cnt <= frames_in_nxt;
            if (out_take) begin
                if (out_beat_cnt == OB_LAST) begin
                    out_beat_cnt   <= '0;
                    frames_out_cnt <= frames_out_cnt + CNT_W'(1);
                end else begin
                    out_beat_cnt <= out_beat_cnt + OB_W'(1);
                end
            end
            // Outside RUN/DRAIN the watchdog is frozen for readback.
            if (counting) begin
                if (out_take || !outstanding || wd_expire) begin
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
            if (lane_fault) begin
                err_lane <= 1'b1;
            end
            if (wd_expire) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Flush pulse timer: restarts whenever we are not flushing, so every
    // FLUSH visit lasts exactly FLUSH_CYCLES cycles.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (state_q != S_FLUSH)) begin
            flush_cnt <= '0;
        end else begin
            flush_cnt <= flush_cnt + FL_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Gated datapath, one register stage. Data follows the source freely;
    // only the valids are gated.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.chain_sig        <= '0;
            bus.chain_sig_tvalid <= '0;
        end else begin
            bus.chain_sig        <= bus.tx_sig;
            bus.chain_sig_tvalid <= admit ? bus.tx_sig_tvalid : 8'h00;
        end
    end

    assign bus.chain_rst = (state_q == S_FLUSH);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DRAIN) && !outstanding;
    assign state         = state_q;

endmodule

// File: tb/tb_dc_rx_sched.sv
// ---------------------------------------------------------------------------
// tb_dc_rx_sched
// Directed bench for dc_rx_sched. The driver pushes {cycle, tvalid, data} of
// every beat it expects in the chain into exp_q; a monitor on the falling edge
// pops and compares whenever chain_sig_tvalid is nonzero. Control/status
// expectations are checked inline by the test sequence.
// ---------------------------------------------------------------------------
module tb_dc_rx_sched;

    localparam int CNT_W = 16;
    localparam int W     = 16 + 8 + 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_enable = 1'b0;
    logic             cfg_start = 1'b0;
    logic [CNT_W-1:0] cfg_num_frames = '0;
    logic             busy, done, err_lane, err_timeout;
    logic [CNT_W-1:0] frames_in_cnt, frames_out_cnt;
    logic [2:0]       state;

    dc_rx_sched_if bus ();

    dc_rx_sched #(
        .IN_BEATS    (8),
        .OUT_BEATS   (8),
        .TIMEOUT     (1024),
        .FLUSH_CYCLES(16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_start     (cfg_start),
        .cfg_num_frames(cfg_num_frames),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err_lane      (err_lane),
        .err_timeout   (err_timeout),
        .frames_in_cnt (frames_in_cnt),
        .frames_out_cnt(frames_out_cnt),
        .state         (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    logic [15:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act, mon_exp;
    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (done) done_seen++;
        if (!rst && bus.chain_sig_tvalid != 8'h00) begin
            total++;
            mon_act = {cyc, bus.chain_sig_tvalid, bus.chain_sig};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL chain_beat_unexpected: got %h want none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL chain_beat: got %h want %h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [7:0][31:0] mk_data(input logic [7:0] tag);
        logic [7:0][31:0] d;
        for (int l = 0; l < 8; l++) d[l] = {tag, 8'(l), 16'hA5C3};
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one input beat for one cycle; adm says whether it must reach the
    // chain one cycle later.
    task automatic beat(input logic [7:0] v, input logic [7:0] tag, input bit adm);
        bus.tx_sig        = mk_data(tag);
        bus.tx_sig_tvalid = v;
        if (adm) exp_q.push_back({cyc + 16'd1, v, mk_data(tag)});
        tick();
    endtask

    task automatic rx_beats(input int n);
        bus.rx_sig_tvalid = 8'hFF;
        for (int i = 0; i < n; i++) tick();
        bus.rx_sig_tvalid = 8'h00;
    endtask

    task automatic start(input logic [CNT_W-1:0] num, input logic en);
        cfg_num_frames = num;
        cfg_enable     = en;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic count_flush(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.chain_rst) n++;
            tick();
        end
    endtask

    // ---------------- test sequence ----------------
    int n, d0;

    initial begin
        bus.tx_sig        = '0;
        bus.tx_sig_tvalid = '0;
        bus.rx_sig_tvalid = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_state", 32'(state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_chain_rst", 32'(bus.chain_rst), 0);
        check("rst_tvalid", 32'(bus.chain_sig_tvalid), 0);
        check("rst_frames_in", 32'(frames_in_cnt), 0);
        rst = 1'b0;
        tick();

        // Normal burst: 2 frames in, 16 output beats back
        d0 = done_seen;
        start(16'd2, 1'b1);
        check("t1_run", 32'(state), 1);
        for (int b = 0; b < 8; b++) beat(8'hFF, 8'(b), 1'b1);
        check("t1_fin_mid", 32'(frames_in_cnt), 1);
        check("t1_still_run", 32'(state), 1);
        for (int b = 8; b < 16; b++) beat(8'hFF, 8'(b), 1'b1);
        bus.tx_sig_tvalid = 8'h00;
        check("t1_drain", 32'(state), 2);
        check("t1_fin", 32'(frames_in_cnt), 2);
        rx_beats(15);
        check("t1_not_done", 32'(done), 0);
        rx_beats(1);
        check("t1_done", 32'(done), 1);
        check("t1_fout", 32'(frames_out_cnt), 2);
        tick();
        check("t1_idle", 32'(state), 0);
        check("t1_done_once", 32'(done_seen - d0), 1);
        check("t1_q_empty", 32'(exp_q.size()), 0);

        // Mid-frame stop in continuous mode
        d0 = done_seen;
        start(16'd0, 1'b1);
        for (int b = 0; b < 4; b++) beat(8'hFF, 8'(8'h20 + b), 1'b1);
        cfg_enable = 1'b0;
        for (int b = 4; b < 8; b++) beat(8'hFF, 8'(8'h20 + b), 1'b1);
        check("t2_drain", 32'(state), 2);
        beat(8'hFF, 8'h28, 1'b0);
        bus.tx_sig_tvalid = 8'h00;
        check("t2_fin", 32'(frames_in_cnt), 1);
        rx_beats(8);
        check("t2_done", 32'(done), 1);
        tick();
        check("t2_idle", 32'(state), 0);
        check("t2_done_once", 32'(done_seen - d0), 1);

        // Lane fault
        d0 = done_seen;
        start(16'd4, 1'b1);
        beat(8'hFF, 8'h30, 1'b1);
        beat(8'hFF, 8'h31, 1'b1);
        beat(8'h7F, 8'h32, 1'b0);
        bus.tx_sig_tvalid = 8'h00;
        check("t3_flush", 32'(state), 3);
        check("t3_err_lane", 32'(err_lane), 1);
        check("t3_busy", 32'(busy), 1);
        count_flush(n);
        check("t3_flush_len", 32'(n), 16);
        check("t3_idle", 32'(state), 0);
        check("t3_err_hold", 32'(err_lane), 1);
        check("t3_no_done", 32'(done_seen - d0), 0);

        // Timeout: one frame, no outputs
        d0 = done_seen;
        start(16'd1, 1'b1);
        check("t4_err_lane_clr", 32'(err_lane), 0);
        for (int b = 0; b < 8; b++) beat(8'hFF, 8'(8'h40 + b), 1'b1);
        bus.tx_sig_tvalid = 8'h00;
        check("t4_drain", 32'(state), 2);
        n = 0;
        while (!err_timeout && n < 2000) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 1024);
        check("t4_flush", 32'(state), 3);
        count_flush(n);
        check("t4_flush_len", 32'(n), 16);
        check("t4_idle", 32'(state), 0);
        check("t4_err_hold", 32'(err_timeout), 1);
        check("t4_fin_hold", 32'(frames_in_cnt), 1);
        check("t4_no_done", 32'(done_seen - d0), 0);

        // Final output beat on the expiry cycle
        d0 = done_seen;
        start(16'd1, 1'b1);
        check("t5_err_to_clr", 32'(err_timeout), 0);
        for (int b = 0; b < 8; b++) beat(8'hFF, 8'(8'h50 + b), 1'b1);
        bus.tx_sig_tvalid = 8'h00;
        rx_beats(7);
        for (int i = 0; i < 1023; i++) tick();
        check("t5_pre_err", 32'(err_timeout), 0);
        check("t5_pre_state", 32'(state), 2);
        rx_beats(1);
        check("t5_err", 32'(err_timeout), 0);
        check("t5_fout", 32'(frames_out_cnt), 1);
        check("t5_done", 32'(done), 1);
        tick();
        check("t5_idle", 32'(state), 0);
        check("t5_done_once", 32'(done_seen - d0), 1);

        // Reset on flush cycle 5
        start(16'd4, 1'b1);
        beat(8'h01, 8'h60, 1'b0);
        bus.tx_sig_tvalid = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        check("t6_in_flush", 32'(bus.chain_rst), 1);
        rst = 1'b1;
        tick();
        check("t6_chain_rst", 32'(bus.chain_rst), 0);
        check("t6_state", 32'(state), 0);
        check("t6_err_lane", 32'(err_lane), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_chain_sig", 32'(|bus.chain_sig), 0);
        rst = 1'b0;
        tick();
        start(16'd3, 1'b0);
        check("t6_no_start", 32'(state), 0);
        check("t6_no_busy", 32'(busy), 0);

        tick(); tick();
        check("final_q_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
